// File: rtl/coeff_fifo_pkg.sv
// Shared constants and pointer helpers for the coefficient replay FIFO.
package coeff_fifo_pkg;

  localparam logic [31:0] CoeffMarkerDefault = 32'h7F90_0000;
  localparam int unsigned CoeffAddrWDefault  = 12;

  // One extra pointer bit separates full from empty when low bits match.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  typedef logic [CoeffAddrWDefault:0] coeff_ptr_t;

endpackage

// File: rtl/coeff_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// resettable output register that holds when no read is issued.
module coeff_dpram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/coeff_replay_fifo.sv
// Coefficient FIFO with replay: reads can be rewound to a committed base.
// Optional level/almost-full outputs are built when COEFF_FIFO_LEVEL_EN is defined.
module coeff_replay_fifo
  import coeff_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] MARKER    = CoeffMarkerDefault,
  parameter int unsigned AF_THRESH = (2**ADDR_W) - 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en,
  input  logic              redo_i,
  input  logic              commit_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              start_o,
`ifdef COEFF_FIFO_LEVEL_EN
  output logic [ADDR_W:0]   level_o,
  output logic              almost_full_o,
`endif
  output logic              drop_o
);

  localparam int unsigned    PtrW    = ptr_width(ADDR_W);
  localparam logic [PtrW-1:0] Depth   = PtrW'(2**ADDR_W);
  localparam logic [DATA_W-1:0] MarkerW = DATA_W'(MARKER);

  typedef logic [PtrW-1:0] ptr_t;

  if (AF_THRESH > 2**ADDR_W) begin : g_bad_af_thresh
    $error("AF_THRESH exceeds FIFO depth");
  end

  ptr_t wr_ptr_d, wr_ptr_q;
  ptr_t rd_ptr_d, rd_ptr_q;
  ptr_t rd_base_d, rd_base_q;
  ptr_t level;
  logic valid_d, valid_q;
  logic start_d, start_q;
  logic drop_d, drop_q;
  logic is_marker, wr_fire, rd_fire;

  // Occupancy counts from rd_base: replayable words still hold their slots.
  assign level   = wr_ptr_q - rd_base_q;
  assign empty_o = (rd_ptr_q == wr_ptr_q);
  assign full_o  = (level == Depth);

  always_comb begin
    is_marker = (data_i == MarkerW);
    wr_fire   = wr_en && !is_marker && !full_o;
    // Commit overrides redo, so a read alongside commit+redo still proceeds.
    rd_fire   = rd_en && !empty_o && (!redo_i || commit_i);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_base_d = rd_base_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (commit_i) begin
      rd_base_d = rd_ptr_q;
    end
    if (redo_i && !commit_i) begin
      rd_ptr_d = rd_base_q;
    end else if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    valid_d = rd_fire;
    start_d = wr_en && is_marker;
    drop_d  = wr_en && !is_marker && full_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_base_q <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_base_q <= rd_base_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      drop_q    <= drop_d;
    end
  end

  coeff_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_i),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (data_o)
  );

  assign valid_o = valid_q;
  assign start_o = start_q;
  assign drop_o  = drop_q;

`ifdef COEFF_FIFO_LEVEL_EN
  assign level_o       = level;
  assign almost_full_o = (level >= PtrW'(AF_THRESH));
`endif

endmodule

// File: tb/tb_coeff_replay_fifo.sv
// Self-checking bench for coeff_replay_fifo (small depth); read data is
// checked against a scoreboard filled from a reference model of the FIFO.
module tb_coeff_replay_fifo;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] MARKER = 32'h7F90_0000;
  localparam logic [AW:0] DepthP = 5'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, redo_i = 1'b0, commit_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        valid_o, full_o, empty_o, start_o, drop_o;
`ifdef COEFF_FIFO_LEVEL_EN
  logic [AW:0] level_o;
  logic        almost_full_o;
`endif

  coeff_replay_fifo #(
    .DATA_W (32),
    .ADDR_W (AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_en         (wr_en),
    .data_i        (data_i),
    .rd_en         (rd_en),
    .redo_i        (redo_i),
    .commit_i      (commit_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .start_o       (start_o),
`ifdef COEFF_FIFO_LEVEL_EN
    .level_o       (level_o),
    .almost_full_o (almost_full_o),
`endif
    .drop_o        (drop_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] m_mem [DEPTH];
  logic [AW:0] m_wr = '0, m_rd = '0, m_base = '0;
  logic        pend_valid = 1'b0;
  logic [31:0] last_data = '0;

  // Scoreboard monitor: valid_o must match the model, data pops in order,
  // and data_o must hold when no word is delivered.
  always begin : monitor
    logic        ev;
    logic [31:0] exp_word;
    @(posedge clk);
    ev = pend_valid;
    #1;
    n_vec++;
    if (valid_o !== ev) begin
      n_err++;
      $display("FAIL valid_o: got %b want %b at %0t", valid_o, ev, $time);
    end
    if (ev) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: got data %h want none queued", data_o);
      end else begin
        exp_word = sb.pop_front();
        last_data = exp_word;
        if (data_o !== exp_word) begin
          n_err++;
          $display("FAIL read_data: got %h want %h at %0t", data_o, exp_word, $time);
        end
      end
    end else begin
      n_vec++;
      if (data_o !== last_data) begin
        n_err++;
        $display("FAIL data_hold: got %h want %h at %0t", data_o, last_data, $time);
      end
    end
  end

  task automatic tick(input logic w, input logic [31:0] d, input logic r,
                      input logic rdo, input logic cm);
    logic        mfull, mempty, do_rd;
    logic [AW:0] old_rd;
    mempty = (m_rd == m_wr);
    mfull  = ((m_wr - m_base) == DepthP);
    wr_en = w; data_i = d; rd_en = r; redo_i = rdo; commit_i = cm;
    do_rd = r && !mempty && (!rdo || cm);
    pend_valid = do_rd;
    if (do_rd) sb.push_back(m_mem[m_rd[AW-1:0]]);
    if (w && d != MARKER && !mfull) begin
      m_mem[m_wr[AW-1:0]] = d;
      m_wr = m_wr + 1'b1;
    end
    old_rd = m_rd;
    if (rdo && !cm) m_rd = m_base;
    else if (do_rd) m_rd = m_rd + 1'b1;
    if (cm) m_base = old_rd;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; redo_i = 1'b0; commit_i = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    last_data = '0; pend_valid = 1'b0; sb.delete();
    m_wr = '0; m_rd = '0; m_base = '0;
    #1;
    n_vec += 6;
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty_o); end
    if (full_o  !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full_o); end
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    if (start_o !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", start_o); end
    if (drop_o  !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b want 0", drop_o); end
    if (data_o  !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", data_o); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL post_rst_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_reset();
    tick(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h1111_0002, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h1111_0003, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (empty_o !== 1'b0) begin n_err++; $display("FAIL pre_rst_empty: got %b want 0", empty_o); end
    do_reset();
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    n_vec++;
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_basic();
    do_reset();
    tick(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 32'h3F80_0000) begin
      n_err++; $display("FAIL basic_first: got %b/%h want 1/3f800000", valid_o, data_o);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 32'h4000_0000) begin
      n_err++; $display("FAIL basic_second: got %b/%h want 1/40000000", valid_o, data_o);
    end
    n_vec++;
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b want 1", empty_o); end
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);  // read on empty is ignored
    idle();
  endtask

  task automatic test_marker();
    do_reset();
    tick(1'b1, MARKER, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (start_o !== 1'b1) begin n_err++; $display("FAIL marker_start: got %b want 1", start_o); end
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL marker_empty: got %b want 1", empty_o); end
    idle();
    n_vec++;
    if (start_o !== 1'b0) begin n_err++; $display("FAIL marker_pulse: got %b want 0", start_o); end
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (full_o !== 1'b1) begin n_err++; $display("FAIL full_set: got %b want 1", full_o); end
    if (empty_o !== 1'b0) begin n_err++; $display("FAIL full_notempty: got %b want 0", empty_o); end
`ifdef COEFF_FIFO_LEVEL_EN
    n_vec += 2;
    if (level_o !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d want 16", level_o); end
    if (almost_full_o !== 1'b1) begin n_err++; $display("FAIL full_af: got %b want 1", almost_full_o); end
`endif
    tick(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (drop_o !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b want 1", drop_o); end
    if (full_o !== 1'b1) begin n_err++; $display("FAIL drop_full: got %b want 1", full_o); end
    tick(1'b1, MARKER, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (drop_o !== 1'b0) begin n_err++; $display("FAIL drop_once: got %b want 0", drop_o); end
    if (start_o !== 1'b1) begin n_err++; $display("FAIL full_marker: got %b want 1", start_o); end
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (full_o !== 1'b1) begin n_err++; $display("FAIL uncommitted_full: got %b want 1", full_o); end
    // Commit in the same cycle as a write must not make room for that write.
    tick(1'b1, 32'hBEEF_0001, 1'b0, 1'b0, 1'b1);
    n_vec += 2;
    if (drop_o !== 1'b1) begin n_err++; $display("FAIL commit_write_drop: got %b want 1", drop_o); end
    if (full_o !== 1'b0) begin n_err++; $display("FAIL commit_frees: got %b want 0", full_o); end
    tick(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if (drop_o !== 1'b0) begin n_err++; $display("FAIL refill_drop: got %b want 0", drop_o); end
    if (full_o !== 1'b1) begin n_err++; $display("FAIL refill_full: got %b want 1", full_o); end
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec += 2;
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty_o); end
    if (full_o !== 1'b0) begin n_err++; $display("FAIL drain_full: got %b want 0", full_o); end
  endtask

  task automatic test_redo();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);  // read blocked by redo
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (data_o !== 32'hA000_0004) begin n_err++; $display("FAIL redo_last: got %h want a0000004", data_o); end
    idle();
  endtask

  task automatic test_commit();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
`ifdef COEFF_FIFO_LEVEL_EN
    n_vec++;
    if (level_o !== 5'd2) begin n_err++; $display("FAIL commit_level: got %0d want 2", level_o); end
`endif
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (data_o !== 32'hB000_0003) begin n_err++; $display("FAIL commit_replay: got %h want b0000003", data_o); end
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_commit_redo();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (data_o !== 32'hC000_0003) begin n_err++; $display("FAIL commit_wins: got %h want c0000003", data_o); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        mfull, mempty;
    do_reset();
    tick(1'b1, 32'hD000_0001, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'hD000_0002, 1'b1, 1'b0, 1'b0);  // write-into-empty read next cycle
    for (int i = 0; i < 60; i++) begin
      d = $urandom;
      if (d == MARKER) d = 32'h0;
      tick(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      mempty = (m_rd == m_wr);
      mfull  = ((m_wr - m_base) == DepthP);
      n_vec += 2;
      if (empty_o !== mempty) begin n_err++; $display("FAIL b2b_empty: got %b want %b", empty_o, mempty); end
      if (full_o !== mfull) begin n_err++; $display("FAIL b2b_full: got %b want %b", full_o, mfull); end
    end
    idle();
    idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    test_reset();
    test_basic();
    test_marker();
    test_full();
    test_redo();
    test_commit();
    test_commit_redo();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d words left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
